// File: rtl/bmp_slave_rx_if.sv
// ---------------------------------------------------------------------------
// bmp_slave_rx_if
// Word stream carrying a BMP file packed little-endian (byte 0 in bits [7:0]).
//   slv_data       : packed file bytes
//   slv_data_valid : slv_data valid (source -> receiver)
//   slv_ready      : receiver accepts the word this cycle (receiver -> source)
// Modports: master = file source, slave = receiver.
// ---------------------------------------------------------------------------
interface bmp_slave_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] slv_data;
    logic                  slv_data_valid;
    logic                  slv_ready;

    modport master (output slv_data, output slv_data_valid, input slv_ready);
    modport slave  (input slv_data, input slv_data_valid, output slv_ready);
endinterface

// File: rtl/bmp_slave_rx.sv
// ---------------------------------------------------------------------------
// bmp_slave_rx
// Receives a 24-bit BMP file as a word stream, validates the header, skips to
// the pixel array, strips row padding and emits one {R,G,B} pixel per
// pix_valid/pix_ready handshake.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   slv               : word stream in (bmp_slave_rx_if.slave)
//   pix_data          : {R,G,B} pixel
//   pix_valid/ready   : pixel handshake
//   pix_sol           : first pixel of a row (qualified by pix_valid)
//   pix_last          : last pixel of the image (qualified by pix_valid)
//   img_width/height  : parsed dimensions, stable while hdr_valid
//   hdr_valid         : header accepted
//   done              : one-cycle pulse at end of file
//   error             : sticky format error, cleared only by rst
// ---------------------------------------------------------------------------
module bmp_slave_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_W      = 12,
    parameter int COLOR_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    bmp_slave_rx_if.slave           slv,
    output logic [3*COLOR_SIZE-1:0] pix_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_sol,
    output logic                    pix_last,
    output logic [DIM_W-1:0]        img_width,
    output logic [DIM_W-1:0]        img_height,
    output logic                    hdr_valid,
    output logic                    done,
    output logic                    error
);

    localparam int LANES  = DATA_WIDTH / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_HDR, S_SKIP, S_PIX, S_PAD, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t r_state, w_state_next;

    // Word buffer
    logic [DATA_WIDTH-1:0] r_word;
    logic [LANE_W-1:0]     r_lane;
    logic                  r_buf_full;
    logic                  r_run;      // holds slv_ready low for the cycle after reset

    // Header fields
    logic [31:0] r_byte_cnt;
    logic [31:0] r_file_size;
    logic [31:0] r_data_start;
    logic [31:0] r_width;
    logic [31:0] r_height;
    logic [7:0]  r_bitcount_lo;

    // Pixel assembly
    logic [7:0]       r_b, r_g;
    logic [1:0]       r_ch;
    logic [DIM_W-1:0] r_col, r_row;
    logic [1:0]       r_pad_cnt;

    // Registered outputs
    logic [3*COLOR_SIZE-1:0] r_pix_data;
    logic                    r_pix_valid, r_pix_sol, r_pix_last;
    logic [DIM_W-1:0]        r_img_width, r_img_height;
    logic                    r_hdr_valid, r_done, r_error;

    // Combinational control
    logic       w_consume, w_flush, w_hdr_ok, w_pix_load, w_done_set;
    logic       w_slv_ready, w_accept;
    logic [7:0] w_byte;
    logic       w_at_end, w_stall, w_last_col, w_last_row, w_hdr_bad;
    logic [15:0] w_bitcount;

    assign w_byte     = r_word[{r_lane, 3'b000} +: 8];
    assign w_at_end   = (r_byte_cnt == r_file_size);
    assign w_last_col = (r_col == r_width[DIM_W-1:0] - DIM_W'(1));
    assign w_last_row = (r_row == r_height[DIM_W-1:0] - DIM_W'(1));
    // Only the byte that would complete a pixel waits on a full output stage.
    assign w_stall    = (r_ch == 2'd2) && r_pix_valid && !pix_ready;

    // Evaluated while byte 29 (bitcount high byte) is on the lane.
    assign w_bitcount = {w_byte, r_bitcount_lo};
    assign w_hdr_bad  = (w_bitcount != 16'd24)
                     || (r_width == 32'd0) || (r_height == 32'd0)
                     || r_height[31]
                     || ((r_width  >> DIM_W) != 32'd0)
                     || ((r_height >> DIM_W) != 32'd0)
                     || (r_data_start < 32'd30)
                     || (r_data_start >= r_file_size);

    // A flush cycle must not accept a word, or the first word of the next
    // file would be thrown away with the tail of this one.
    assign w_slv_ready = r_run && ((r_state == S_ERR) ||
                         ((!r_buf_full || (w_consume && r_lane == LAST_LANE)) && !w_flush));
    assign w_accept    = slv.slv_data_valid && w_slv_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_HDR;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_consume    = 1'b0;
        w_flush      = 1'b0;
        w_hdr_ok     = 1'b0;
        w_pix_load   = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            S_HDR: begin
                if (r_buf_full) begin
                    w_consume = 1'b1;
                    if (r_byte_cnt == 32'd0 && w_byte != 8'h42)      w_state_next = S_ERR;
                    else if (r_byte_cnt == 32'd1 && w_byte != 8'h4D) w_state_next = S_ERR;
                    else if (r_byte_cnt == 32'd29) begin
                        if (w_hdr_bad) w_state_next = S_ERR;
                        else begin
                            w_hdr_ok     = 1'b1;
                            w_state_next = S_SKIP;
                        end
                    end
                end
            end
            S_SKIP: begin
                if (r_byte_cnt == r_data_start) w_state_next = S_PIX;
                else if (r_buf_full)            w_consume    = 1'b1;
            end
            S_PIX: begin
                if (w_at_end) w_state_next = S_ERR;   // file ended inside the pixel array
                else if (r_buf_full && !w_stall) begin
                    w_consume = 1'b1;
                    if (r_ch == 2'd2) begin
                        w_pix_load = 1'b1;
                        if (w_last_col) begin
                            if (w_last_row)                 w_state_next = S_DRAIN;
                            else if (r_width[1:0] != 2'd0)  w_state_next = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                if (w_at_end) w_state_next = S_ERR;
                else if (r_buf_full) begin
                    w_consume = 1'b1;
                    if (r_pad_cnt == r_width[1:0] - 2'd1) w_state_next = S_PIX;
                end
            end
            S_DRAIN: begin
                if (w_at_end) begin
                    w_flush      = 1'b1;              // drop lanes past end of file
                    w_state_next = S_DONE;
                end else if (r_buf_full) begin
                    w_consume = 1'b1;
                end
            end
            S_DONE: begin
                if (!r_pix_valid) begin
                    w_done_set   = 1'b1;
                    w_state_next = S_HDR;
                end
            end
            default: w_state_next = S_ERR;            // S_ERR: held until rst
        endcase
    end

    // NOTE: r_word is not reset; r_buf_full alone says whether it holds data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_lane     <= '0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_state == S_ERR || w_flush) begin
                r_buf_full <= 1'b0;
                r_lane     <= '0;
            end else if (w_accept) begin
                r_word     <= slv.slv_data;
                r_buf_full <= 1'b1;
                r_lane     <= '0;
            end else if (w_consume) begin
                if (r_lane == LAST_LANE) r_buf_full <= 1'b0;
                else                     r_lane     <= r_lane + LANE_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt    <= '0;
            r_file_size   <= '0;
            r_data_start  <= '0;
            r_width       <= '0;
            r_height      <= '0;
            r_bitcount_lo <= '0;
            r_b           <= '0;
            r_g           <= '0;
            r_ch          <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_pad_cnt     <= '0;
            r_pix_data    <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_sol     <= 1'b0;
            r_pix_last    <= 1'b0;
            r_img_width   <= '0;
            r_img_height  <= '0;
            r_hdr_valid   <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_consume) r_byte_cnt <= r_byte_cnt + 32'd1;

            // Little-endian fields shift in from the top, LSB byte first.
            if (w_consume && r_state == S_HDR) begin
                if (r_byte_cnt >= 32'd2  && r_byte_cnt <= 32'd5)  r_file_size  <= {w_byte, r_file_size[31:8]};
                if (r_byte_cnt >= 32'd10 && r_byte_cnt <= 32'd13) r_data_start <= {w_byte, r_data_start[31:8]};
                if (r_byte_cnt >= 32'd18 && r_byte_cnt <= 32'd21) r_width      <= {w_byte, r_width[31:8]};
                if (r_byte_cnt >= 32'd22 && r_byte_cnt <= 32'd25) r_height     <= {w_byte, r_height[31:8]};
                if (r_byte_cnt == 32'd28)                         r_bitcount_lo <= w_byte;
            end

            if (w_hdr_ok) begin
                r_hdr_valid  <= 1'b1;
                r_img_width  <= r_width[DIM_W-1:0];
                r_img_height <= r_height[DIM_W-1:0];
                r_ch         <= '0;
                r_col        <= '0;
                r_row        <= '0;
                r_pad_cnt    <= '0;
            end

            // BMP stores each pixel as B, G, R.
            if (w_consume && r_state == S_PIX) begin
                case (r_ch)
                    2'd0:    begin r_b <= w_byte; r_ch <= 2'd1; end
                    2'd1:    begin r_g <= w_byte; r_ch <= 2'd2; end
                    default: begin
                        r_ch <= 2'd0;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + DIM_W'(1);
                        end else begin
                            r_col <= r_col + DIM_W'(1);
                        end
                    end
                endcase
            end

            if (w_consume && r_state == S_PAD) begin
                if (r_pad_cnt == r_width[1:0] - 2'd1) r_pad_cnt <= '0;
                else                                  r_pad_cnt <= r_pad_cnt + 2'd1;
            end

            if (w_state_next == S_ERR) begin
                r_error     <= 1'b1;
                r_pix_valid <= 1'b0;
            end else if (w_pix_load) begin
                r_pix_data  <= {w_byte, r_g, r_b};
                r_pix_valid <= 1'b1;
                r_pix_sol   <= (r_col == '0);
                r_pix_last  <= w_last_col && w_last_row;
            end else if (pix_ready) begin
                r_pix_valid <= 1'b0;
            end

            if (w_done_set) begin
                r_byte_cnt  <= '0;
                r_hdr_valid <= 1'b0;
            end
        end
    end

    assign slv.slv_ready = w_slv_ready;
    assign pix_data      = r_pix_data;
    assign pix_valid     = r_pix_valid;
    assign pix_sol       = r_pix_sol;
    assign pix_last      = r_pix_last;
    assign img_width     = r_img_width;
    assign img_height    = r_img_height;
    assign hdr_valid     = r_hdr_valid;
    assign done          = r_done;
    assign error         = r_error;

endmodule

// File: tb/tb_bmp_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_bmp_slave_rx
// Builds small BMP files in a byte array, streams them into bmp_slave_rx and
// checks every pixel handshake against a queue computed from the file bytes
// using the standard BMP row stride. A few literal pixel values pin the model.
// ---------------------------------------------------------------------------
module tb_bmp_slave_rx;

    localparam int DW    = 32;
    localparam int DIM_W = 12;
    localparam int LANES = DW / 8;

    typedef struct {
        logic [23:0]      data;
        logic             sol;
        logic             last;
        logic [DIM_W-1:0] w;
        logic [DIM_W-1:0] h;
    } pix_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [23:0]      pix_data;
    logic             pix_valid, pix_ready, pix_sol, pix_last;
    logic [DIM_W-1:0] img_width, img_height;
    logic             hdr_valid, done, error;

    bmp_slave_rx_if #(.DATA_WIDTH(DW)) slv_if ();

    bmp_slave_rx #(.DATA_WIDTH(DW), .DIM_W(DIM_W), .COLOR_SIZE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .slv        (slv_if),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sol    (pix_sol),
        .pix_last   (pix_last),
        .img_width  (img_width),
        .img_height (img_height),
        .hdr_valid  (hdr_valid),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] file_mem [0:255];
    pix_t       exp_q [$];
    logic       m_hdr_ok;

    logic [23:0] cap_data [0:15];
    logic        cap_sol  [0:15];
    logic        cap_last [0:15];
    int          cap_n       = 0;
    int          done_cnt    = 0;
    int          hdr_falls   = 0;
    int          words_acc   = 0;
    int          done_target = 0;
    logic        bp_mode     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] rd32(input int a);
        return {file_mem[a+3], file_mem[a+2], file_mem[a+1], file_mem[a]};
    endfunction

    // File layout: 'BM' header, 0xEE filler up to data_start, pixel bytes
    // 0x11,0x22,... with zero padding, zeros up to file_size, 0xFF beyond.
    task automatic build_bmp(input int base, input int w, input int h, input int ds,
                             input int fs, input int bits, input logic [7:0] b0);
        int stride, n;
        stride = ((24 * w + 31) / 32) * 4;
        for (int i = 0; i < 128; i++) file_mem[base+i] = 8'hFF;
        for (int i = 0; i < fs; i++)  file_mem[base+i] = 8'h00;
        for (int i = 30; i < ds; i++) file_mem[base+i] = 8'hEE;
        file_mem[base+0] = b0;
        file_mem[base+1] = 8'h4D;
        for (int k = 0; k < 4; k++) begin
            file_mem[base+2+k]  = 8'(fs >> (8*k));
            file_mem[base+10+k] = 8'(ds >> (8*k));
            file_mem[base+14+k] = 8'(40 >> (8*k));
            file_mem[base+18+k] = 8'(w  >> (8*k));
            file_mem[base+22+k] = 8'(h  >> (8*k));
        end
        file_mem[base+26] = 8'd1;
        file_mem[base+28] = 8'(bits);
        file_mem[base+29] = 8'(bits >> 8);
        n = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < 3 * w; c++) begin
                file_mem[base + ds + r*stride + c] = 8'(8'h11 * (n + 1));
                n++;
            end
    endtask

    // Expected pixels straight from the file bytes and BMP rules.
    task automatic load_model(input int base);
        logic [31:0] fs, ds, w, h, bits;
        int stride, o;
        pix_t p;
        fs   = rd32(base+2);
        ds   = rd32(base+10);
        w    = rd32(base+18);
        h    = rd32(base+22);
        bits = {16'h0, file_mem[base+29], file_mem[base+28]};
        m_hdr_ok = (file_mem[base] == 8'h42) && (file_mem[base+1] == 8'h4D) && (bits == 24)
                && (w > 0) && (h > 0) && (w < (1 << DIM_W)) && (h < (1 << DIM_W))
                && (ds >= 30) && (ds < fs);
        if (m_hdr_ok) begin
            stride = ((24 * int'(w) + 31) / 32) * 4;
            for (int r = 0; r < int'(h); r++)
                for (int c = 0; c < int'(w); c++) begin
                    o      = base + int'(ds) + r*stride + 3*c;
                    p.data = {file_mem[o+2], file_mem[o+1], file_mem[o]};
                    p.sol  = (c == 0);
                    p.last = (r == int'(h) - 1) && (c == int'(w) - 1);
                    p.w    = w[DIM_W-1:0];
                    p.h    = h[DIM_W-1:0];
                    exp_q.push_back(p);
                end
        end
    endtask

    task automatic send_words(input int base, input int nwords);
        int budget;
        for (int i = 0; i < nwords; i++) begin
            for (int l = 0; l < LANES; l++) slv_if.slv_data[8*l +: 8] = file_mem[base + LANES*i + l];
            slv_if.slv_data_valid = 1'b1;
            budget = 200;
            @(negedge clk);
            while (!slv_if.slv_ready && budget > 0) begin
                budget--;
                @(negedge clk);
            end
            if (budget == 0) begin
                check("slv_ready_timeout", 32'(i), 32'(nwords));
                i = nwords;
            end else begin
                @(posedge clk);
                #1;
                words_acc++;
            end
        end
        slv_if.slv_data_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int budget = 1000;
        while (done_cnt < target && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        check("done_count", 32'(done_cnt), 32'(target));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        slv_if.slv_data_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sink ready: constant 1, or toggling every 3 cycles.
    initial begin
        int bp_cnt = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bp_cnt++;
                if (bp_cnt == 3) begin
                    bp_cnt = 0;
                    pix_ready = !pix_ready;
                end
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model queue.
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data;
    logic [1:0]  prev_flags;
    logic        hdr_prev = 1'b0;

    always @(negedge clk) begin
        pix_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, pix_valid}, 32'd1);
                check("stall_data", {8'd0, pix_data}, {8'd0, prev_data});
                check("stall_flags", {30'd0, pix_sol, pix_last}, {30'd0, prev_flags});
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pix_unexpected: got pixel 0x%06h, required no pixel", pix_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", {8'd0, pix_data}, {8'd0, e.data});
                    check("pix_sol", {31'd0, pix_sol}, {31'd0, e.sol});
                    check("pix_last", {31'd0, pix_last}, {31'd0, e.last});
                    check("img_width", 32'(img_width), 32'(e.w));
                    check("img_height", 32'(img_height), 32'(e.h));
                    check("hdr_valid_pix", {31'd0, hdr_valid}, 32'd1);
                end
                if (cap_n < 16) begin
                    cap_data[cap_n] = pix_data;
                    cap_sol[cap_n]  = pix_sol;
                    cap_last[cap_n] = pix_last;
                end
                cap_n++;
            end
            if (error) begin
                check("err_slv_ready", {31'd0, slv_if.slv_ready}, 32'd1);
                check("err_pix_valid", {31'd0, pix_valid}, 32'd0);
            end
            if (done) done_cnt++;
            if (hdr_prev && !hdr_valid) hdr_falls++;
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_flags = {pix_sol, pix_last};
        end
        hdr_prev = hdr_valid;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_slv_ready"}, {31'd0, slv_if.slv_ready}, 32'd0);
        check({tag, "_pix"}, {5'd0, pix_data, pix_valid, pix_sol, pix_last}, 32'd0);
        check({tag, "_dims"}, {8'd0, img_width, img_height}, 32'd0);
        check({tag, "_status"}, {29'd0, hdr_valid, done, error}, 32'd0);
    endtask

    initial begin
        int falls0;
        rst = 1'b1;
        slv_if.slv_data_valid = 1'b0;
        slv_if.slv_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // 1: 2x2, ds=54, fs=70
        build_bmp(0, 2, 2, 54, 70, 24, 8'h42);
        load_model(0);
        cap_n = 0; words_acc = 0;
        send_words(0, 18);
        done_target++;
        wait_done(done_target);
        check("t1_words", 32'(words_acc), 32'd18);
        check("t1_npix", 32'(cap_n), 32'd4);
        check("t1_pix0", {8'd0, cap_data[0]}, 32'h332211);
        check("t1_pix1", {8'd0, cap_data[1]}, 32'h665544);
        check("t1_pix2", {8'd0, cap_data[2]}, 32'h998877);
        check("t1_pix3", {8'd0, cap_data[3]}, 32'hCCBBAA);
        check("t1_sol", {28'd0, cap_sol[3], cap_sol[2], cap_sol[1], cap_sol[0]}, 32'b0101);
        check("t1_last", {28'd0, cap_last[3], cap_last[2], cap_last[1], cap_last[0]}, 32'b1000);
        check("t1_left", 32'(exp_q.size()), 32'd0);
        check("t1_error", {31'd0, error}, 32'd0);

        // 2: 3x1, ds=58, fs=70, 3 pad bytes, 2 trailing bytes
        build_bmp(0, 3, 1, 58, 70, 24, 8'h42);
        load_model(0);
        cap_n = 0;
        send_words(0, 18);
        done_target++;
        wait_done(done_target);
        check("t2_npix", 32'(cap_n), 32'd3);
        check("t2_pix2", {8'd0, cap_data[2]}, 32'h998877);
        check("t2_last", {29'd0, cap_last[2], cap_last[1], cap_last[0]}, 32'b100);
        check("t2_left", 32'(exp_q.size()), 32'd0);

        // 3: test-1 file under backpressure
        bp_mode = 1'b1;
        build_bmp(0, 2, 2, 54, 70, 24, 8'h42);
        load_model(0);
        cap_n = 0;
        send_words(0, 18);
        done_target++;
        wait_done(done_target);
        bp_mode = 1'b0;
        check("t3_npix", 32'(cap_n), 32'd4);
        check("t3_pix3", {8'd0, cap_data[3]}, 32'hCCBBAA);
        check("t3_left", 32'(exp_q.size()), 32'd0);

        // 4a: bitcount = 8
        do_reset();
        build_bmp(0, 2, 2, 54, 70, 8, 8'h42);
        load_model(0);
        send_words(0, 7);
        wait_cycles(8);
        check("t4a_err_early", {31'd0, error}, 32'd0);
        send_words(0 + 4*7, 1);
        wait_cycles(4);
        check("t4a_err", {31'd0, error}, {31'd0, !m_hdr_ok});
        send_words(4*8, 10);
        wait_cycles(10);
        check("t4a_err_hold", {31'd0, error}, 32'd1);
        check("t4a_hdr", {31'd0, hdr_valid}, 32'd0);

        // 4b: byte 0 = 0x41
        do_reset();
        check("t4b_err_cleared", {31'd0, error}, 32'd0);
        build_bmp(0, 2, 2, 54, 70, 24, 8'h41);
        load_model(0);
        cap_n = 0;
        send_words(0, 1);
        wait_cycles(2);
        check("t4b_err", {31'd0, error}, {31'd0, !m_hdr_ok});
        send_words(4, 17);
        wait_cycles(5);
        check("t4b_err_hold", {31'd0, error}, 32'd1);
        check("t4b_npix", 32'(cap_n), 32'd0);
        do_reset();

        // 5: reset during row 1, then full retransmission
        build_bmp(0, 2, 2, 54, 70, 24, 8'h42);
        load_model(0);
        send_words(0, 16);
        wait_cycles(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("t5_reset");
        @(posedge clk);
        #1;
        load_model(0);
        cap_n = 0; words_acc = 0;
        send_words(0, 18);
        done_target++;
        wait_done(done_target);
        check("t5_npix", 32'(cap_n), 32'd4);
        check("t5_words", 32'(words_acc), 32'd18);
        check("t5_left", 32'(exp_q.size()), 32'd0);

        // 6: two files back-to-back
        build_bmp(0, 2, 2, 54, 70, 24, 8'h42);
        build_bmp(128, 3, 1, 58, 70, 24, 8'h42);
        load_model(0);
        load_model(128);
        cap_n = 0;
        falls0 = hdr_falls;
        send_words(0, 18);
        send_words(128, 18);
        done_target += 2;
        wait_done(done_target);
        check("t6_npix", 32'(cap_n), 32'd7);
        check("t6_hdr_falls", 32'(hdr_falls - falls0), 32'd2);
        check("t6_left", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bmp_slave_rx.md
Name: bmp_slave_rx

Overview:
- Receiving end of the slave byte-stream interface: consumes a BMP file packed little-endian into DATA_WIDTH-bit words (byte 0 in bits [7:0]) with a valid/ready handshake.
- Parses and validates the BMP header, skips to the pixel array, strips row padding and emits one 24-bit pixel per handshake to the processing core.
- Sits between slave port 0 and the pixel datapath of the image processing accelerator.

Parameters:
- DATA_WIDTH, 32, slave word width; multiple of 8; byte lanes = DATA_WIDTH/8.
- DIM_W, 12, width of the width/height counters; maximum dimension is 2^DIM_W-1.
- COLOR_SIZE, 8, bits per colour channel; fixed at 8 for 24-bit BMP.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- slv_data  in  DATA_WIDTH  packed file bytes, little-endian.
- slv_data_valid  in  1  slv_data valid.
- slv_ready  out  1  word accepted when slv_data_valid && slv_ready.
- pix_data  out  3*COLOR_SIZE  {R,G,B}.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts pixel.
- pix_sol  out  1  first pixel of a row; qualified by pix_valid.
- pix_last  out  1  last pixel of the image; qualified by pix_valid.
- img_width  out  DIM_W  parsed width.
- img_height  out  DIM_W  parsed height.
- hdr_valid  out  1  header accepted; dimensions are stable.
- done  out  1  one-cycle pulse at end of file.
- error  out  1  sticky format error.

Behaviour:
- Reset values: slv_ready=0, pix_valid=0, pix_sol=0, pix_last=0, pix_data=0, img_width=0, img_height=0, hdr_valid=0, done=0, error=0, state=HDR, byte_cnt=0.
- Reset takes effect on any cycle, mid-file included: the partial word is dropped, any pending pixel is dropped, and the next accepted word is treated as file byte 0.
- Word buffer:
  - An accepted word is unpacked at one byte per cycle, lane 0 first.
  - slv_ready=1 when the buffer is empty, or when its last lane is consumed this cycle and no stall is present. Back-to-back throughput is 1 word per DATA_WIDTH/8 cycles.
  - byte_cnt (32 bits) increments on every consumed byte.
- Byte stall: when a byte completes a pixel while pix_valid=1 && !pix_ready, the byte is held.
- States and transitions:
  - HDR: captures bytes 0-29.
    - Bytes 0,1 must be 0x42,0x4D.
    - file_size = bytes 5..2; data_start = bytes 13..10; width = bytes 21..18; height = bytes 25..22; bitcount = bytes 29..28.
    - After byte 29: go to ERR if bitcount!=24, width==0, height==0, height[31]==1 (top-down is not supported), width or height >= 2^DIM_W, or data_start<30 or data_start>=file_size.
    - Otherwise set hdr_valid=1 and go to SKIP.
  - SKIP: discards bytes until byte_cnt==data_start, then goes to PIX.
  - PIX: gathers B, G, R into a pixel.
    - On the R byte, the pixel register loads and pix_valid=1.
    - Column and row counters advance.
    - After the last column of a row, go to PAD if width[1:0]!=0; otherwise stay in PIX.
    - After the last pixel of the last row, go to DRAIN.
  - PAD: discards exactly width[1:0] bytes, then returns to PIX.
  - DRAIN: discards bytes until byte_cnt==file_size.
    - Bytes of the final word beyond file_size are ignored.
    - Go to DONE.
  - DONE: waits until pix_valid==0, pulses done for 1 cycle, clears hdr_valid and byte_cnt, then returns to HDR for the next file.
  - ERR: error=1 and stays set. slv_ready=1 and all words are sunk. pix_valid=0. Exit only by rst.
- Pixel output:
  - pix_data, pix_sol and pix_last hold stable while pix_valid && !pix_ready.
  - pix_valid deasserts on handshake unless a new pixel loads in the same cycle.
  - pix_sol=1 for column 0; pix_last=1 for the last column of the last row.
- If file_size is reached before the pixel array is complete: go to ERR.

Test Plan:
- 2x2, 24-bit, data_start=54, file_size=70, pix_ready=1. Row bytes are 11 22 33 44 55 66 00 00 / 77 88 99 AA BB CC 00 00. Expect pix_data 0x332211, 0x665544, 0x998877, 0xCCBBAA; pix_sol on pixels 1 and 3; pix_last on pixel 4; hdr_valid=1 with img_width=2, img_height=2; a single done pulse; 18 words accepted.
- 3x1, data_start=58 (4 skip bytes), file_size=70. Expect 3 pixels with pix_last on the 3rd; 3 PAD bytes and the trailing 2 bytes discarded; done pulse.
- Backpressure: same file as test 1 with pix_ready toggling 1/0 every 3 cycles. Expect the identical pixel sequence, no pixel lost or duplicated, and pix_data stable while stalled.
- Bad header: bitcount=8, then a separate run with byte 0=0x41. Expect error=1 after byte 29 (respectively after byte 0), zero pixels, slv_ready held 1, error persists until rst.
- Reset mid-stream: assert rst for 1 cycle during row 1 of test 1. Expect all outputs at reset values next cycle; a full retransmitted file then yields exactly 4 pixels and done.
- Two files back-to-back without reset. Expect 2 done pulses and hdr_valid to deassert between the files.
